// File: rtl/prbs_gen_chk_pkg.sv
// prbs_gen_chk_pkg: checker FSM encodings shared by the PRBS generator/checker slice.
package prbs_gen_chk_pkg;
    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SYNC     = 2'd1,
        ST_LOCKED   = 2'd2
    } chk_state_e;
endpackage

// File: rtl/prbs_checker.sv
// prbs_checker: self-synchronising Galois PRBS checker with lock FSM and saturating error counter.
module prbs_checker
    import prbs_gen_chk_pkg::*;
#(
    parameter int          W          = 8,
    parameter logic [W-1:0] POLY      = 8'h1D,
    parameter int          LOCK_CNT   = 4,
    parameter int          UNLOCK_CNT = 4,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chk_valid,
    input  logic [W-1:0]     chk_data,
    output logic             lock,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);

    function automatic logic [W-1:0] nxt(input logic [W-1:0] s);
        return {s[W-2:0], 1'b0} ^ (s[W-1] ? POLY : '0);
    endfunction

    chk_state_e       st, st_n;
    logic [W-1:0]     expect_q, expect_n;
    logic [MW-1:0]    match_cnt, match_n;
    logic [UW-1:0]    miss_cnt, miss_n;
    logic [CNT_W-1:0] err_n;

    always_comb begin
        st_n     = st;
        expect_n = expect_q;
        match_n  = match_cnt;
        miss_n   = miss_cnt;
        err_n    = err_cnt;
        if (chk_valid) begin
            case (st)
                ST_UNLOCKED: begin
                    if (chk_data != '0) begin
                        expect_n = nxt(chk_data);
                        match_n  = '0;
                        st_n     = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    expect_n = nxt(chk_data);
                    if (chk_data == expect_q) begin
                        match_n = (match_cnt == MW'(LOCK_CNT - 1)) ? '0 : match_cnt + 1'b1;
                        st_n    = (match_cnt == MW'(LOCK_CNT - 1)) ? ST_LOCKED : ST_SYNC;
                        miss_n  = '0;
                    end else begin
                        match_n = '0;
                        st_n    = (chk_data == '0) ? ST_UNLOCKED : ST_SYNC;
                    end
                end
                ST_LOCKED: begin
                    // flywheel: the expected sequence no longer follows received data
                    expect_n = nxt(expect_q);
                    if (chk_data == expect_q) begin
                        miss_n = '0;
                    end else begin
                        err_n  = (&err_cnt) ? err_cnt : err_cnt + 1'b1;
                        miss_n = (miss_cnt == UW'(UNLOCK_CNT - 1)) ? '0 : miss_cnt + 1'b1;
                        st_n   = (miss_cnt == UW'(UNLOCK_CNT - 1)) ? ST_UNLOCKED : ST_LOCKED;
                    end
                end
                default: st_n = ST_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ST_UNLOCKED;
            expect_q  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_cnt   <= '0;
        end else begin
            st        <= st_n;
            expect_q  <= expect_n;
            match_cnt <= match_n;
            miss_cnt  <= miss_n;
            err_cnt   <= err_n;
        end
    end

    assign lock = (st == ST_LOCKED);
endmodule

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: Galois-LFSR PRBS generator plus self-synchronising checker.
// Define PRBS_ERR_INJECT_EN to add i_err_inject (single-bit error injection on o_data).
module prbs_gen_chk
    import prbs_gen_chk_pkg::*;
#(
    parameter int           W          = 8,
    parameter logic [W-1:0] POLY       = 8'h1D,
    parameter logic [W-1:0] SEED_DEF   = 8'h01,
    parameter int           LOCK_CNT   = 4,
    parameter int           UNLOCK_CNT = 4,
    parameter int           CNT_W      = 16
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_soft_reset,
    input  logic             i_valid,
    input  logic [W-1:0]     i_seed,
    input  logic             i_chk_valid,
    input  logic [W-1:0]     i_chk_data,
`ifdef PRBS_ERR_INJECT_EN
    input  logic             i_err_inject,
`endif
    output logic [W-1:0]     o_data,
    output logic             o_valid,
    output logic             o_lock,
    output logic [CNT_W-1:0] o_err_cnt
);
    function automatic logic [W-1:0] nxt(input logic [W-1:0] s);
        return {s[W-2:0], 1'b0} ^ (s[W-1] ? POLY : '0);
    endfunction

    logic [W-1:0] lfsr;
    logic         inj_q;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            lfsr    <= SEED_DEF;
            o_valid <= 1'b0;
        end else if (i_soft_reset) begin
            // an all-zero seed would lock the LFSR at zero forever
            lfsr    <= (i_seed == '0) ? SEED_DEF : i_seed;
            o_valid <= 1'b0;
        end else begin
            o_valid <= i_valid;
            if (i_valid)
                lfsr <= nxt(lfsr);
        end
    end

`ifdef PRBS_ERR_INJECT_EN
    always_ff @(posedge clk) begin
        if (i_rst || i_soft_reset)
            inj_q <= 1'b0;
        else
            inj_q <= i_valid & i_err_inject;
    end
`else
    assign inj_q = 1'b0;
`endif

    assign o_data = lfsr ^ {{(W-1){1'b0}}, inj_q};

    prbs_checker #(
        .W(W), .POLY(POLY), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(CNT_W)
    ) u_chk (
        .clk       (clk),
        .rst       (i_rst | i_soft_reset),
        .chk_valid (i_chk_valid),
        .chk_data  (i_chk_data),
        .lock      (o_lock),
        .err_cnt   (o_err_cnt)
    );
endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk: directed self-checking bench for prbs_gen_chk with default parameters.
module tb_prbs_gen_chk;
    logic        clk = 1'b0;
    logic        i_rst, i_soft_reset, i_valid, i_chk_valid_drv;
    logic [7:0]  i_seed, chk_data_drv, flip;
    logic        loop;
    logic        i_chk_valid;
    logic [7:0]  i_chk_data;
    logic [7:0]  o_data;
    logic        o_valid, o_lock;
    logic [15:0] o_err_cnt;
`ifdef PRBS_ERR_INJECT_EN
    logic        i_err_inject = 1'b0;
`endif
    int pass = 0;
    int total = 0;

    always #5 clk = ~clk;

    assign i_chk_valid = loop ? o_valid : i_chk_valid_drv;
    assign i_chk_data  = loop ? (o_data ^ flip) : chk_data_drv;

    prbs_gen_chk dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_soft_reset (i_soft_reset),
        .i_valid      (i_valid),
        .i_seed       (i_seed),
        .i_chk_valid  (i_chk_valid),
        .i_chk_data   (i_chk_data),
`ifdef PRBS_ERR_INJECT_EN
        .i_err_inject (i_err_inject),
`endif
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_lock       (o_lock),
        .o_err_cnt    (o_err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic soft_reset(input logic [7:0] s);
        i_seed = s;
        i_soft_reset = 1'b1;
        tick();
        i_soft_reset = 1'b0;
    endtask

    task automatic do_lock();
        i_valid = 1'b0;
        soft_reset(8'h01);
        loop = 1'b1;
        flip = 8'h00;
        i_valid = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        total++; if (o_data !== 8'h01) $display("FAIL reset_data got=%h exp=01", o_data); else pass++;
        total++; if (o_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", o_valid); else pass++;
        total++; if (o_lock !== 1'b0) $display("FAIL reset_lock got=%b exp=0", o_lock); else pass++;
        total++; if (o_err_cnt !== 16'd0) $display("FAIL reset_err got=%0d exp=0", o_err_cnt); else pass++;
        i_rst = 1'b0;
    endtask

    task automatic test_sequence();
        logic [7:0] seq [9] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
        int n = 9;
        i_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            total++; if (o_data !== seq[i]) $display("FAIL seq_%0d got=%h exp=%h", i, o_data, seq[i]); else pass++;
        end
        total++; if (o_valid !== 1'b1) $display("FAIL seq_valid got=%b exp=1", o_valid); else pass++;
        while (o_data !== 8'h01 && n < 300) begin
            tick();
            n++;
        end
        total++; if (n !== 255) $display("FAIL period got=%0d exp=255", n); else pass++;
        i_valid = 1'b0;
        tick();
        total++; if (o_valid !== 1'b0) $display("FAIL valid_drop got=%b exp=0", o_valid); else pass++;
    endtask

    task automatic test_soft_reset();
        i_valid = 1'b0;
        soft_reset(8'hAA);
        total++; if (o_data !== 8'hAA) $display("FAIL soft_seed got=%h exp=AA", o_data); else pass++;
        soft_reset(8'h00);
        total++; if (o_data !== 8'h01) $display("FAIL soft_zero got=%h exp=01", o_data); else pass++;
        repeat (3) tick();
        total++; if (o_data !== 8'h01) $display("FAIL hold got=%h exp=01", o_data); else pass++;
    endtask

    task automatic test_lock();
        i_valid = 1'b0;
        soft_reset(8'h01);
        loop = 1'b1;
        flip = 8'h00;
        i_valid = 1'b1;
        repeat (5) tick();
        total++; if (o_lock !== 1'b0) $display("FAIL lock_early got=%b exp=0", o_lock); else pass++;
        tick();
        total++; if (o_lock !== 1'b1) $display("FAIL lock_rise got=%b exp=1", o_lock); else pass++;
        total++; if (o_data !== 8'h40) $display("FAIL lock_data got=%h exp=40", o_data); else pass++;
        repeat (3) tick();
        total++; if (o_err_cnt !== 16'd0) $display("FAIL lock_err got=%0d exp=0", o_err_cnt); else pass++;
    endtask

    task automatic test_errors();
        flip = 8'h01;
        tick();
        flip = 8'h00;
        total++; if (o_err_cnt !== 16'd1) $display("FAIL single_err got=%0d exp=1", o_err_cnt); else pass++;
        total++; if (o_lock !== 1'b1) $display("FAIL single_lock got=%b exp=1", o_lock); else pass++;
        repeat (3) tick();
        total++; if (o_err_cnt !== 16'd1) $display("FAIL flywheel_err got=%0d exp=1", o_err_cnt); else pass++;
        do_lock();
        flip = 8'h01;
        repeat (3) tick();
        total++; if (o_lock !== 1'b1) $display("FAIL miss3_lock got=%b exp=1", o_lock); else pass++;
        total++; if (o_err_cnt !== 16'd3) $display("FAIL miss3_err got=%0d exp=3", o_err_cnt); else pass++;
        tick();
        total++; if (o_lock !== 1'b0) $display("FAIL miss4_lock got=%b exp=0", o_lock); else pass++;
        total++; if (o_err_cnt !== 16'd4) $display("FAIL miss4_err got=%0d exp=4", o_err_cnt); else pass++;
        repeat (2) tick();
        flip = 8'h00;
        tick();
        total++; if (o_err_cnt !== 16'd4) $display("FAIL unlocked_err got=%0d exp=4", o_err_cnt); else pass++;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        total++; if (o_err_cnt !== 16'd0) $display("FAIL rst_mid_err got=%0d exp=0", o_err_cnt); else pass++;
        total++; if (o_lock !== 1'b0) $display("FAIL rst_mid_lock got=%b exp=0", o_lock); else pass++;
        total++; if (o_data !== 8'h01) $display("FAIL rst_mid_data got=%h exp=01", o_data); else pass++;
    endtask

    task automatic test_zero_and_gaps();
        logic [7:0] words [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
        int n = 0;
        i_valid = 1'b0;
        soft_reset(8'h01);
        loop = 1'b0;
        i_chk_valid_drv = 1'b1;
        chk_data_drv = 8'h00;
        repeat (6) tick();
        total++; if (o_lock !== 1'b0) $display("FAIL zero_lock got=%b exp=0", o_lock); else pass++;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                i_chk_valid_drv = 1'b0;
                chk_data_drv = 8'hFF;
                repeat (3) tick();
                i_chk_valid_drv = 1'b1;
            end
            chk_data_drv = words[i];
            tick();
            if (i == 3) begin
                total++; if (o_lock !== 1'b0) $display("FAIL gap_early got=%b exp=0", o_lock); else pass++;
            end
        end
        total++; if (o_lock !== 1'b1) $display("FAIL gap_lock got=%b exp=1", o_lock); else pass++;
        i_chk_valid_drv = 1'b0;
        soft_reset(8'h5C);
        loop = 1'b1;
        flip = 8'h00;
        while (o_lock !== 1'b1 && n < 400) begin
            i_valid = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        total++; if (o_lock !== 1'b1) $display("FAIL rand_lock got=%b exp=1 cycles=%0d", o_lock, n); else pass++;
        total++; if (o_err_cnt !== 16'd0) $display("FAIL rand_err got=%0d exp=0", o_err_cnt); else pass++;
    endtask

`ifdef PRBS_ERR_INJECT_EN
    task automatic test_inject();
        do_lock();
        i_err_inject = 1'b1;
        tick();
        i_err_inject = 1'b0;
        total++; if (o_data !== 8'h81) $display("FAIL inj_word got=%h exp=81", o_data); else pass++;
        tick();
        total++; if (o_data !== 8'h1D) $display("FAIL inj_resume got=%h exp=1D", o_data); else pass++;
        total++; if (o_err_cnt !== 16'd1) $display("FAIL inj_err got=%0d exp=1", o_err_cnt); else pass++;
        repeat (3) tick();
        total++; if (o_lock !== 1'b1) $display("FAIL inj_lock got=%b exp=1", o_lock); else pass++;
        total++; if (o_err_cnt !== 16'd1) $display("FAIL inj_err_hold got=%0d exp=1", o_err_cnt); else pass++;
    endtask
`endif

    initial begin
        i_rst = 1'b1;
        i_soft_reset = 1'b0;
        i_valid = 1'b0;
        i_seed = 8'h00;
        i_chk_valid_drv = 1'b0;
        chk_data_drv = 8'h00;
        flip = 8'h00;
        loop = 1'b0;
        test_reset();
        test_sequence();
        test_soft_reset();
        test_lock();
        test_errors();
        test_zero_and_gaps();
`ifdef PRBS_ERR_INJECT_EN
        test_inject();
`endif
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
